imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle RV32I core's instruction memory write port. It receives a byte stream from a UART receiver, assembles little-endian 32-bit words and writes them sequentially into instruction memory. It verifies an XOR checksum and holds the core in reset until a valid image has been loaded. Integration muxes `A_i_mem` onto the instruction memory address while `core_reset` is high.

## Interface
- `ADDR_W`, 10: instruction memory byte-address width.
- `MAX_WORDS`, 256: largest accepted image, in words (2^ADDR_W / 4).
- `TIMEOUT`, 1_000_000: idle clock cycles allowed between bytes inside a transfer before the loader aborts.
- `clk` in 1: single clock; all state changes on its rising edge.
- `Reset_n` in 1: synchronous, active-low reset.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid; may be high on consecutive cycles.
- `rx_data` in 8: received byte.
- `core_reset` out 1: active-high reset to the core (its `Reset`); high until load succeeds.
- `WE_i_mem` out 1: instruction memory write enable, one-cycle pulse per word.
- `WD_i_mem` out 32: word to write.
- `A_i_mem` out ADDR_W: byte address of the write; word-aligned.
- `busy` out 1: transfer in progress.
- `done` out 1: image loaded and verified; core running.
- `error` out 1: last transfer failed.

## Operation
- Frame format: LEN_LO, LEN_HI (word count N, little-endian 16 bit), then 4·N payload bytes (each word LSB first), then CHK = XOR of all payload bytes.
- States:
  - LEN_LO: idle, awaiting first byte.
  - LEN_HI.
  - DATA.
  - CHECK.
  - RUN.
  - ERROR.
- LEN_LO: byte → latch low count, `busy`=1, clear `error`, go to LEN_HI.
- LEN_HI: byte → form N.
  - N==0 or N>MAX_WORDS → ERROR.
  - Otherwise clear byte index, word index, address and checksum; go to DATA.
- DATA: each byte is shifted into bits [8·k+7:8·k] for byte index k=0..3 and XORed into the running checksum.
  - On k==3: register the word and address, pulse `WE_i_mem`.
  - After the N-th word go to CHECK.
- CHECK: byte equal to running checksum → RUN. Byte not equal → ERROR.
- RUN: `core_reset`=0, `done`=1, `busy`=0. All `rx_valid` strobes are ignored. Only `Reset_n` leaves RUN.
- ERROR: `error`=1, `busy`=0, `core_reset`=1. The next `rx_valid` byte is treated as LEN_LO and the loader restarts; `error` clears on that byte.
  - Memory contents written before the failure are left as is.
- Address arithmetic: the word at index i is written at `A_i_mem` = 4·i, width ADDR_W. N≤MAX_WORDS guarantees no wrap.
- Timeout counter:
  - Active in LEN_HI, DATA and CHECK; cleared on every accepted byte and on state entry.
  - Reaching TIMEOUT → ERROR.
  - If `rx_valid` arrives in the same cycle the count expires, the byte is accepted and the timeout does not fire.

## Timing
- Reset values (while `Reset_n`=0 at an edge): state LEN_LO.
  - `core_reset`=1, `WE_i_mem`=0, `WD_i_mem`=0, `A_i_mem`=0.
  - `busy`=0, `done`=0, `error`=0.
  - Counters and checksum cleared.
- Reset mid-transfer: the next edge with `Reset_n`=0 forces the above values. Any pending write is dropped (`WE_i_mem`=0).
- No backpressure: a byte is accepted on every edge where `rx_valid`=1.
- Write latency: when the 4th byte of a word is accepted at edge t, `WE_i_mem`=1 during cycle t..t+1 with `WD_i_mem`/`A_i_mem` stable, then returns to 0.
  - `A_i_mem` holds the last written address until the next write; the next write presents address +4.
- Back-to-back bytes sustain one word every 4 cycles.
- CHK accepted at edge t → `core_reset` falls and `done` rises at t (visible from cycle t+1).
  - The last `WE_i_mem` pulse has already completed by then, since CHK arrives at least one cycle after the last payload byte.
- Error detection (bad length, bad checksum, timeout) is visible on `error` the cycle after the causing edge.

## Test plan
- Valid load: bytes 02 00 13 00 00 00 93 00 10 00 90 →
  - `WE_i_mem` pulses with A=0, WD=0x00000013, then A=4, WD=0x00100093.
  - `core_reset` 1→0 and `done`=1 one cycle after byte 0x90; `error`=0.
- Bad checksum: same frame ending 0x91 → two writes occur; then `error`=1, `done`=0, `core_reset` stays 1.
  - Re-sending the valid frame afterwards → `done`=1.
- Bad length: 00 00 → `error`=1 after the second byte, no `WE_i_mem`.
  - 01 01 (N=257) → `error`=1, no `WE_i_mem`.
- Timeout (TIMEOUT=16): 01 00 13 00, then silence → `error`=1 exactly 16 cycles after the last byte, no `WE_i_mem`.
  - Variant: byte arriving on cycle 16 → accepted, no error.
- Reset mid-DATA: drop `Reset_n` for one edge after 5 payload bytes → all outputs at reset values.
  - A subsequent full valid load starts writing at A=0.
- RUN immunity: after a valid load, send 10 random bytes → no `WE_i_mem`, `core_reset`=0, `done`=1 throughout.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the RV32I core's instruction memory.
// Receives a UART byte stream framed as LEN_LO, LEN_HI, 4*N payload bytes
// (little-endian words), then an XOR checksum byte. Each completed word is written
// sequentially into instruction memory. The core is held in reset until a frame
// with a matching checksum has been loaded.
//
// Ports:
//   clk        - system clock, rising edge
//   Reset_n    - synchronous active-low reset
//   rx_valid   - one-cycle strobe qualifying rx_data
//   rx_data    - received byte
//   core_reset - active-high reset to the core, released after a verified load
//   WE_i_mem   - one-cycle instruction memory write pulse per word
//   WD_i_mem   - write data
//   A_i_mem    - word-aligned byte address of the write
//   busy       - transfer in progress
//   done       - image loaded and verified, core running
//   error      - last transfer failed
//
// state  | meaning
// -------+------------------------------------------------------------
// LEN_LO | idle, waiting for low byte of word count
// LEN_HI | waiting for high byte of word count
// DATA   | collecting payload bytes, writing one word per 4 bytes
// CHECK  | waiting for checksum byte
// RUN    | image verified, core released; input ignored until reset
// ERROR  | transfer failed; next byte restarts as LEN_LO
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256,
  parameter int TIMEOUT   = 1_000_000
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              core_reset,
  output logic              WE_i_mem,
  output logic [31:0]       WD_i_mem,
  output logic [ADDR_W-1:0] A_i_mem,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [15:0]   MAX_N    = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t              state_q;
  logic [15:0]         len_q;
  logic [15:0]         word_cnt_q;
  logic [1:0]          byte_idx_q;
  logic [23:0]         word_q;
  logic [7:0]          chk_q;
  logic [ADDR_W-1:0]   addr_cnt_q;
  logic [TW-1:0]       tmo_q;
  logic                core_reset_q;
  logic                we_q;
  logic [31:0]         wd_q;
  logic [ADDR_W-1:0]   a_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;

  logic        timing;
  logic [15:0] n_word;

  // Timeout only runs while a frame is partially received.
  assign timing = (state_q == S_LEN_HI) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign n_word = {rx_data, len_q[7:0]};

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q      <= S_LEN_LO;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      chk_q        <= '0;
      addr_cnt_q   <= '0;
      tmo_q        <= '0;
      core_reset_q <= 1'b1;
      we_q         <= 1'b0;
      wd_q         <= '0;
      a_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (timing && !rx_valid) begin
        // A byte on the expiry cycle takes the else branch and wins.
        if (tmo_q == TMO_LAST) begin
          tmo_q   <= '0;
          state_q <= S_ERROR;
          error_q <= 1'b1;
          busy_q  <= 1'b0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
        case (state_q)
          S_LEN_LO, S_ERROR: begin
            if (rx_valid) begin
              len_q[7:0] <= rx_data;
              busy_q     <= 1'b1;
              error_q    <= 1'b0;
              state_q    <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            if (n_word == 16'd0 || n_word > MAX_N) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              len_q      <= n_word;
              byte_idx_q <= '0;
              word_cnt_q <= '0;
              addr_cnt_q <= '0;
              chk_q      <= '0;
              state_q    <= S_DATA;
            end
          end
          S_DATA: begin
            chk_q <= chk_q ^ rx_data;
            if (byte_idx_q == 2'd3) begin
              we_q       <= 1'b1;
              wd_q       <= {rx_data, word_q};
              a_q        <= addr_cnt_q;
              addr_cnt_q <= addr_cnt_q + ADDR_W'(4);
              word_cnt_q <= word_cnt_q + 16'd1;
              byte_idx_q <= '0;
              if (word_cnt_q == len_q - 16'd1) begin
                state_q <= S_CHECK;
              end
            end else begin
              case (byte_idx_q)
                2'd0:    word_q[7:0]   <= rx_data;
                2'd1:    word_q[15:8]  <= rx_data;
                default: word_q[23:16] <= rx_data;
              endcase
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end
          S_CHECK: begin
            if (rx_data == chk_q) begin
              state_q      <= S_RUN;
              core_reset_q <= 1'b0;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign core_reset = core_reset_q;
  assign WE_i_mem   = we_q;
  assign WD_i_mem   = wd_q;
  assign A_i_mem    = a_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (TIMEOUT overridden to 16).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        core_reset, WE_i_mem, busy, done, error;
  logic [31:0] WD_i_mem;
  logic [9:0]  A_i_mem;

  int nvec = 0;
  int nerr = 0;

  logic [9:0]  wr_a[$];
  logic [31:0] wr_d[$];

  imem_loader #(.ADDR_W(10), .MAX_WORDS(256), .TIMEOUT(16)) dut (
    .clk(clk), .Reset_n(Reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .core_reset(core_reset), .WE_i_mem(WE_i_mem), .WD_i_mem(WD_i_mem),
    .A_i_mem(A_i_mem), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Write log: one sample per cycle shortly after the rising edge.
  always @(posedge clk) begin
    #1;
    if (WE_i_mem === 1'b1) begin
      wr_a.push_back(A_i_mem);
      wr_d.push_back(WD_i_mem);
    end
  end

  // All stimulus tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);
    wr_a.delete();
    wr_d.delete();
  endtask

  task automatic check_flags(input string name, input logic cr, input logic bz,
                             input logic dn, input logic er);
    nvec++;
    if ({core_reset, busy, done, error} !== {cr, bz, dn, er}) begin
      nerr++;
      $display("FAIL %s: {core_reset,busy,done,error} got %b%b%b%b want %b%b%b%b",
               name, core_reset, busy, done, error, cr, bz, dn, er);
    end
  endtask

  task automatic check_writes(input string name, input int n,
                              input logic [9:0] a0, input logic [31:0] d0,
                              input logic [9:0] a1, input logic [31:0] d1);
    nvec++;
    if (wr_a.size() != n) begin
      nerr++;
      $display("FAIL %s: write count got %0d want %0d", name, wr_a.size(), n);
    end else begin
      if (n > 0 && (wr_a[0] !== a0 || wr_d[0] !== d0)) begin
        nerr++;
        $display("FAIL %s: write0 got A=%h WD=%h want A=%h WD=%h", name, wr_a[0], wr_d[0], a0, d0);
      end
      if (n > 1 && (wr_a[1] !== a1 || wr_d[1] !== d1)) begin
        nerr++;
        $display("FAIL %s: write1 got A=%h WD=%h want A=%h WD=%h", name, wr_a[1], wr_d[1], a1, d1);
      end
    end
  endtask

  logic [7:0] frame [11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h10, 8'h00, 8'h90};

  task automatic send_frame(input logic [7:0] last);
    for (int i = 0; i < 10; i++) send_byte(frame[i]);
    send_byte(last);
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if ({WE_i_mem, WD_i_mem, A_i_mem} !== 43'd0) begin
      nerr++;
      $display("FAIL reset_bus: WE=%b WD=%h A=%h want all 0", WE_i_mem, WD_i_mem, A_i_mem);
    end
    check_flags("reset_flags", 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_valid_load();
    do_reset();
    send_byte(8'h02);
    check_flags("busy_after_len_lo", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 6; i++) send_byte(frame[i]);
    nvec++;
    if (WE_i_mem !== 1'b1 || A_i_mem !== 10'h000 || WD_i_mem !== 32'h00000013) begin
      nerr++;
      $display("FAIL write_latency: WE=%b A=%h WD=%h want 1 000 00000013", WE_i_mem, A_i_mem, WD_i_mem);
    end
    send_byte(frame[6]);
    nvec++;
    if (WE_i_mem !== 1'b0 || A_i_mem !== 10'h000) begin
      nerr++;
      $display("FAIL write_pulse_end: WE=%b A=%h want 0 000", WE_i_mem, A_i_mem);
    end
    for (int i = 7; i < 10; i++) send_byte(frame[i]);
    check_flags("before_chk", 1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h90);
    check_flags("valid_load", 1'b0, 1'b0, 1'b1, 1'b0);
    check_writes("valid_writes", 2, 10'h000, 32'h00000013, 10'h004, 32'h00100093);
  endtask

  task automatic test_bad_checksum();
    do_reset();
    send_frame(8'h91);
    check_flags("bad_chk", 1'b1, 1'b0, 1'b0, 1'b1);
    check_writes("bad_chk_writes", 2, 10'h000, 32'h00000013, 10'h004, 32'h00100093);
    wr_a.delete();
    wr_d.delete();
    send_byte(8'h02);
    check_flags("error_clears", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 11; i++) send_byte(frame[i]);
    check_flags("reload_after_err", 1'b0, 1'b0, 1'b1, 1'b0);
    check_writes("reload_writes", 2, 10'h000, 32'h00000013, 10'h004, 32'h00100093);
  endtask

  task automatic test_bad_length();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    check_flags("len_zero", 1'b1, 1'b0, 1'b0, 1'b1);
    send_byte(8'h01);
    send_byte(8'h01);
    check_flags("len_257", 1'b1, 1'b0, 1'b0, 1'b1);
    check_writes("bad_len_no_write", 0, '0, '0, '0, '0);
    // N = 256 is the largest legal length.
    send_byte(8'h00);
    send_byte(8'h01);
    check_flags("len_256_ok", 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
    for (int i = 0; i < 15; i++) @(negedge clk);
    check_flags("tmo_not_yet", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_flags("tmo_fired", 1'b1, 1'b0, 1'b0, 1'b1);
    check_writes("tmo_no_write", 0, '0, '0, '0, '0);

    do_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
    for (int i = 0; i < 15; i++) @(negedge clk);
    send_byte(8'h00);
    check_flags("tmo_rescued", 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_data();
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(frame[i]);
    Reset_n = 1'b0;
    @(negedge clk);
    Reset_n = 1'b1;
    nvec++;
    if ({WE_i_mem, WD_i_mem, A_i_mem} !== 43'd0) begin
      nerr++;
      $display("FAIL mid_reset_bus: WE=%b WD=%h A=%h want all 0", WE_i_mem, WD_i_mem, A_i_mem);
    end
    check_flags("mid_reset_flags", 1'b1, 1'b0, 1'b0, 1'b0);
    wr_a.delete();
    wr_d.delete();
    send_frame(8'h90);
    check_flags("load_after_reset", 1'b0, 1'b0, 1'b1, 1'b0);
    check_writes("writes_after_reset", 2, 10'h000, 32'h00000013, 10'h004, 32'h00100093);
  endtask

  task automatic test_run_immunity();
    int bad;
    do_reset();
    send_frame(8'h90);
    wr_a.delete();
    wr_d.delete();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      if (core_reset !== 1'b0 || done !== 1'b1 || busy !== 1'b0) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL run_immunity_flags: bad cycles got %0d want 0", bad);
    end
    check_writes("run_no_write", 0, '0, '0, '0, '0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_valid_load();
    test_bad_checksum();
    test_bad_length();
    test_timeout();
    test_reset_mid_data();
    test_run_immunity();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
